// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the instruction/data main-memory port arbiter.
// A word is carried as a byte array with element [0] holding the most significant byte.
package mem_arb_pkg;

    localparam int unsigned BYTES_PER_WORD = 4;

    typedef logic [0:BYTES_PER_WORD-1][7:0] word_t;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_e;

    typedef enum logic {
        GNT_INSTR,
        GNT_DATA
    } grant_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester handshakes plus the single memory port, bundled for the arbiter.
// slave is the arbiter's view; master is the view of the core, caches and memory model.
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR_W = 32
);
    import mem_arb_pkg::*;

    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_ready;
    word_t             i_rdata;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    word_t             d_wdata;
    logic              d_ready;
    word_t             d_rdata;

    logic [ADDR_W-1:0] mem_addr;
    word_t             mem_data_in;
    logic              mem_write_en;
    word_t             mem_data_out;

    logic              busy;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_data_out,
        output i_ready, i_rdata, d_ready, d_rdata, mem_addr, mem_data_in, mem_write_en, busy
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_data_out,
        input  i_ready, i_rdata, d_ready, d_rdata, mem_addr, mem_data_in, mem_write_en, busy
    );

endinterface

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Two-way round-robin chooser: a lone request wins outright, a tie goes to the
// requester that was not granted last.
module rr_pick2
    import mem_arb_pkg::*;
(
    input  logic   i_req_i,
    input  logic   d_req_i,
    input  grant_e last_grant_i,
    output logic   valid_o,
    output grant_e winner_o
);

    always_comb begin
        valid_o  = i_req_i | d_req_i;
        winner_o = GNT_INSTR;
        if (i_req_i && d_req_i) begin
            winner_o = (last_grant_i == GNT_INSTR) ? GNT_DATA : GNT_INSTR;
        end else if (d_req_i) begin
            winner_o = GNT_DATA;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency memory port between instruction fetch and data cache traffic.
// Each access: grant in IDLE, MEM_LATENCY cycles of ACCESS, one RESP cycle with a ready pulse.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned MEM_LATENCY = 2,
    parameter int unsigned ADDR_W      = 32
) (
    input logic               clk,
    input logic               rst,
    mem_port_arbiter_if.slave bus
);

    localparam int unsigned   CntW    = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [CntW-1:0] CntLoad = CntW'(MEM_LATENCY - 1);

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    grant_e            last_q, last_d;
    grant_e            win_q, win_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    word_t             wdata_q, wdata_d;
    word_t             irdata_q, irdata_d;
    word_t             drdata_q, drdata_d;

    logic              pick_valid;
    grant_e            pick_win;

    rr_pick2 u_pick (
        .i_req_i      (bus.i_req),
        .d_req_i      (bus.d_req),
        .last_grant_i (last_q),
        .valid_o      (pick_valid),
        .winner_o     (pick_win)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        last_d   = last_q;
        win_d    = win_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        irdata_d = irdata_q;
        drdata_d = drdata_q;

        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    win_d   = pick_win;
                    last_d  = pick_win;
                    cnt_d   = CntLoad;
                    state_d = ACCESS;
                    if (pick_win == GNT_DATA) begin
                        we_d    = bus.d_we;
                        addr_d  = {bus.d_addr[ADDR_W-1:2], 2'b00};
                        wdata_d = bus.d_wdata;
                    end else begin
                        we_d    = 1'b0;
                        addr_d  = {bus.i_addr[ADDR_W-1:2], 2'b00};
                    end
                end
            end
            ACCESS: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    // Final cycle: read data is valid on the closing edge.
                    if (!we_q) begin
                        if (win_q == GNT_INSTR) begin
                            irdata_d = bus.mem_data_out;
                        end else begin
                            drdata_d = bus.mem_data_out;
                        end
                    end
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            last_q   <= GNT_INSTR;
            win_q    <= GNT_INSTR;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            irdata_q <= '0;
            drdata_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            last_q   <= last_d;
            win_q    <= win_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            irdata_q <= irdata_d;
            drdata_q <= drdata_d;
        end
    end

    assign bus.mem_addr     = addr_q;
    assign bus.mem_data_in  = wdata_q;
    assign bus.mem_write_en = (state_q == ACCESS) && (cnt_q == '0) && we_q;
    assign bus.i_ready      = (state_q == RESP) && (win_q == GNT_INSTR);
    assign bus.d_ready      = (state_q == RESP) && (win_q == GNT_DATA);
    assign bus.i_rdata      = irdata_q;
    assign bus.d_rdata      = drdata_q;
    assign bus.busy         = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: an occupancy-countdown model checked every cycle on the
// MEM_LATENCY=2 instance, plus directed literal checks on both the 2- and 1-latency builds.
module tb_mem_port_arbiter;

    localparam int unsigned ML = 2;
    localparam int unsigned AW = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(AW)) bus  ();
    mem_port_arbiter_if #(.ADDR_W(AW)) bus1 ();

    mem_port_arbiter #(.MEM_LATENCY(ML), .ADDR_W(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    mem_port_arbiter #(.MEM_LATENCY(1), .ADDR_W(AW)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    int n_cmp = 0;
    int n_bad = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_0104) return 32'hDEAD_BEEF;
        return {a[15:0], ~a[15:0]};
    endfunction

    assign bus.mem_data_out  = mem_word(bus.mem_addr);
    assign bus1.mem_data_out = mem_word(bus1.mem_addr);

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: m_left counts cycles of occupancy left (ACCESS cycles then one RESP cycle).
    int          m_left;
    bit          m_last, m_win, m_we; // 1 = data
    logic [31:0] m_addr, m_wdata, m_ird, m_drd;

    function automatic bit winner(input bit ir, input bit dr, input bit last);
        if (ir && dr) return !last;
        return dr;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_left  <= 0;
            m_last  <= 1'b0;
            m_win   <= 1'b0;
            m_we    <= 1'b0;
            m_addr  <= 32'h0;
            m_wdata <= 32'h0;
            m_ird   <= 32'h0;
            m_drd   <= 32'h0;
        end else if (m_left == 0) begin
            if (bus.i_req || bus.d_req) begin
                m_win  <= winner(bus.i_req, bus.d_req, m_last);
                m_last <= winner(bus.i_req, bus.d_req, m_last);
                m_we   <= winner(bus.i_req, bus.d_req, m_last) && bus.d_we;
                m_addr <= (winner(bus.i_req, bus.d_req, m_last) ? bus.d_addr : bus.i_addr)
                          & ~32'h3;
                m_wdata <= bus.d_wdata;
                m_left  <= ML + 1;
            end
        end else begin
            if (m_left == 2 && !m_we) begin
                if (m_win) m_drd <= mem_word(m_addr);
                else       m_ird <= mem_word(m_addr);
            end
            m_left <= m_left - 1;
        end
    end

    always @(negedge clk) begin
        cmp("busy",     32'(bus.busy),         32'(m_left != 0));
        cmp("i_ready",  32'(bus.i_ready),      32'(m_left == 1 && !m_win));
        cmp("d_ready",  32'(bus.d_ready),      32'(m_left == 1 && m_win));
        cmp("write_en", 32'(bus.mem_write_en), 32'(m_left == 2 && m_we));
        cmp("mem_addr", bus.mem_addr,          m_addr);
        cmp("i_rdata",  bus.i_rdata,           m_ird);
        cmp("d_rdata",  bus.d_rdata,           m_drd);
        if (m_left == 2 && m_we) cmp("mem_data_in", bus.mem_data_in, m_wdata);
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input bit on1, input bit data, input bit v, input bit we,
                         input logic [31:0] addr, input logic [31:0] wdata);
        if (on1) begin
            if (data) begin
                bus1.d_req = v; bus1.d_we = we; bus1.d_addr = addr; bus1.d_wdata = wdata;
            end else begin
                bus1.i_req = v; bus1.i_addr = addr;
            end
        end else begin
            if (data) begin
                bus.d_req = v; bus.d_we = we; bus.d_addr = addr; bus.d_wdata = wdata;
            end else begin
                bus.i_req = v; bus.i_addr = addr;
            end
        end
    endtask

    // Raises a request, lets the next edge sample it and reports the ready cycle offset.
    task automatic do_access(input bit on1, input bit data, input bit we,
                             input logic [31:0] addr, input logic [31:0] wdata, input bit drop,
                             output int lat, output int wecnt, output int we_at,
                             output logic [31:0] we_addr, output logic [31:0] we_data);
        bit          rdy, wen;
        logic [31:0] ma, md;
        lat = 0; wecnt = 0; we_at = 0; we_addr = 32'h0; we_data = 32'h0;
        drive(on1, data, 1'b1, we, addr, wdata);
        @(posedge clk);
        if (drop) begin
            #1;
            drive(on1, data, 1'b0, we, addr, wdata);
        end
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (on1) begin
                rdy = data ? bus1.d_ready : bus1.i_ready;
                wen = bus1.mem_write_en; ma = bus1.mem_addr; md = bus1.mem_data_in;
            end else begin
                rdy = data ? bus.d_ready : bus.i_ready;
                wen = bus.mem_write_en; ma = bus.mem_addr; md = bus.mem_data_in;
            end
            if (wen) begin
                wecnt++; we_at = k; we_addr = ma; we_data = md;
            end
            if (rdy) begin
                lat = k;
                drive(on1, data, 1'b0, we, addr, wdata);
                break;
            end
        end
        cmp("ready_seen", 32'(lat != 0), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int          lat, wecnt, we_at, n;
        logic [31:0] wa, wd;
        bit          ord [0:2];
        int          at  [0:2];

        bus.i_req = 0; bus.i_addr = 0; bus.d_req = 0; bus.d_we = 0;
        bus.d_addr = 0; bus.d_wdata = 0;
        bus1.i_req = 0; bus1.i_addr = 0; bus1.d_req = 0; bus1.d_we = 0;
        bus1.d_addr = 0; bus1.d_wdata = 0;

        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        tick();
        cmp("reset_busy",     32'(bus.busy), 32'd0);
        cmp("reset_mem_addr", bus.mem_addr,  32'h0);
        cmp("reset_i_rdata",  bus.i_rdata,   32'h0);

        // Single fetch.
        do_access(0, 0, 0, 32'h0000_0104, 32'h0, 0, lat, wecnt, we_at, wa, wd);
        cmp("fetch_latency", 32'(lat),   32'd3);
        cmp("fetch_no_we",   32'(wecnt), 32'd0);
        tick();
        cmp("fetch_rdata",   bus.i_rdata,         32'hDEAD_BEEF);
        cmp("fetch_byte0",   32'(bus.i_rdata[0]), 32'hDE);

        // Data read to set d_rdata, then an unaligned write that must not disturb it.
        do_access(0, 1, 0, 32'h0000_0300, 32'h0, 0, lat, wecnt, we_at, wa, wd);
        tick();
        cmp("dread_rdata", bus.d_rdata, 32'h0300_FCFF);
        do_access(0, 1, 1, 32'h0000_0203, 32'h1122_3344, 0, lat, wecnt, we_at, wa, wd);
        cmp("write_latency", 32'(lat),   32'd3);
        cmp("write_we_cnt",  32'(wecnt), 32'd1);
        cmp("write_we_at",   32'(we_at), 32'd2);
        cmp("write_addr",    wa,         32'h0000_0200);
        cmp("write_data",    wd,         32'h1122_3344);
        cmp("write_byte0",   32'(wd[31:24]), 32'h11);
        tick();
        cmp("write_keeps_d_rdata", bus.d_rdata, 32'h0300_FCFF);

        // Tie right after reset: D, I, D.
        rst = 1'b1; tick(); rst = 1'b0; tick();
        bus.i_req = 1; bus.i_addr = 32'h40;
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h80;
        @(posedge clk);
        n = 0;
        for (int k = 1; k <= 20 && n < 3; k++) begin
            @(negedge clk);
            if (bus.d_ready) begin ord[n] = 1'b1; at[n] = k; n++; end
            else if (bus.i_ready) begin ord[n] = 1'b0; at[n] = k; n++; end
        end
        bus.i_req = 0; bus.d_req = 0;
        cmp("tie_count", 32'(n), 32'd3);
        if (n == 3) begin
            cmp("tie_first_data",  32'(ord[0]), 32'd1);
            cmp("tie_first_at",    32'(at[0]),  32'd3);
            cmp("tie_second_inst", 32'(ord[1]), 32'd0);
            cmp("tie_second_at",   32'(at[1]),  32'd7);
            cmp("tie_third_data",  32'(ord[2]), 32'd1);
            cmp("tie_third_at",    32'(at[2]),  32'd11);
        end
        tick();
        cmp("tie_i_rdata", bus.i_rdata, 32'h0040_FFBF);
        cmp("tie_d_rdata", bus.d_rdata, 32'h0080_FF7F);

        // Reset during the first ACCESS cycle, request held throughout.
        bus.i_req = 1; bus.i_addr = 32'h0000_0104;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        cmp("rst_mid_busy",     32'(bus.busy),    32'd0);
        cmp("rst_mid_i_ready",  32'(bus.i_ready), 32'd0);
        cmp("rst_mid_mem_addr", bus.mem_addr,     32'h0);
        cmp("rst_mid_i_rdata",  bus.i_rdata,      32'h0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        do_access(0, 0, 0, 32'h0000_0104, 32'h0, 0, lat, wecnt, we_at, wa, wd);
        cmp("restart_latency", 32'(lat), 32'd3);
        tick();
        cmp("restart_rdata", bus.i_rdata, 32'hDEAD_BEEF);

        // Request dropped right after the grant.
        do_access(0, 1, 0, 32'h0000_03F0, 32'h0, 1, lat, wecnt, we_at, wa, wd);
        cmp("drop_latency", 32'(lat), 32'd3);
        @(negedge clk);
        cmp("drop_idle_busy", 32'(bus.busy), 32'd0);
        cmp("drop_rdata",     bus.d_rdata,   32'h03F0_FC0F);
        tick();

        // MEM_LATENCY=1 build.
        do_access(1, 0, 0, 32'h0000_0104, 32'h0, 0, lat, wecnt, we_at, wa, wd);
        cmp("ml1_fetch_latency", 32'(lat), 32'd2);
        tick();
        cmp("ml1_fetch_rdata", bus1.i_rdata, 32'hDEAD_BEEF);
        do_access(1, 1, 1, 32'h0000_0010, 32'hCAFE_F00D, 0, lat, wecnt, we_at, wa, wd);
        cmp("ml1_write_latency", 32'(lat),   32'd2);
        cmp("ml1_write_we_cnt",  32'(wecnt), 32'd1);
        cmp("ml1_write_we_at",   32'(we_at), 32'd1);
        cmp("ml1_write_data",    wd,         32'hCAFE_F00D);
        tick(); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single word-wide main-memory port between the instruction-fetch path and the data cache refill/writeback path of the pipelined MIPS core.
- Grants one requester at a time using round-robin.
- Sequences a fixed-latency memory access and returns read data with a one-cycle ready pulse.
- Sits between the core/cache request interfaces and the memory model.

Parameters:
- MEM_LATENCY, 2: cycles an address must be held before read data is valid or a write commits. Legal range is 1 or more.
- ADDR_W, 32: byte address width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- i_req  in  1  instruction-fetch read request. Held until i_ready.
- i_addr  in  ADDR_W  fetch byte address.
- i_ready  out  1  one-cycle pulse: fetch complete, i_rdata valid.
- i_rdata  out  4x8  fetch word. Byte array, [0] is the MSB byte.
- d_req  in  1  data request. Held until d_ready.
- d_we  in  1  data write (1) or read (0). Stable while d_req is high.
- d_addr  in  ADDR_W  data byte address.
- d_wdata  in  4x8  data write word.
- d_ready  out  1  one-cycle pulse: data access complete.
- d_rdata  out  4x8  data read word.
- mem_addr  out  ADDR_W  memory address, word-aligned.
- mem_data_in  out  4x8  write data to memory.
- mem_write_en  out  1  memory write strobe.
- mem_data_out  in  4x8  read data from memory.
- busy  out  1  high when state is not IDLE.

Behaviour:
- Reset (asynchronous, any cycle, including mid-access):
  - State goes to IDLE; counter to 0; last_grant to INSTR.
  - Every output is 0: i_ready, d_ready, i_rdata, d_rdata, mem_addr, mem_data_in, mem_write_en, busy.
  - An in-flight access is abandoned; no ready pulse is issued for it.
- States: IDLE, ACCESS, RESP.
- IDLE, with either req sampled high:
  - Choose the winner.
  - Latch winner, we (0 for fetch), addr with [1:0] forced to 00, and wdata.
  - Load counter with MEM_LATENCY-1.
  - Go to ACCESS.
- Winner selection:
  - Only one request: that requester.
  - Both requests: the requester opposite last_grant. After reset, data wins the first tie.
  - last_grant updates at grant time.
- ACCESS:
  - mem_addr and mem_data_in are driven from the latched values every cycle.
  - When counter is nonzero: decrement.
  - When counter is 0: this is the final cycle.
    - mem_write_en is 1 in this cycle only, and only if the latched we is 1.
    - At the closing edge of a read, mem_data_out is captured into the winner's rdata register.
    - Go to RESP.
- RESP:
  - The winner's ready is 1 for exactly this cycle.
  - rdata holds until the next read completion for that requester.
  - On a write, d_rdata is unchanged.
  - Go to IDLE unconditionally; there is no back-to-back grant from RESP.
- Timing: req sampled in IDLE at edge T gives ready high in cycle T+MEM_LATENCY+1, then IDLE again. Per-access occupancy is MEM_LATENCY+2 cycles.
- Requester protocol:
  - Deassert req (or present a new request) on the edge that ends the ready cycle.
  - A req that stays high in IDLE is treated as a new request.
- Request dropped mid-access: the access still completes and ready still pulses; the arbiter ignores the protocol violation.
- Address or wdata change mid-access: no effect, because latched values are used.
- mem_addr outside ACCESS: holds the last value (0 after reset). mem_write_en is never high outside ACCESS.
- The losing requester is not acknowledged and keeps waiting. Round-robin bounds its wait to one access.

Decomposition:
- Package mem_arb_pkg holds:
  - state enum {IDLE, ACCESS, RESP};
  - grant enum {GNT_INSTR, GNT_DATA};
  - localparam BYTES_PER_WORD = 4;
  - the word-as-byte-array typedef.
- Sub-module rr_pick2: combinational two-way round-robin chooser (reqs, last_grant → winner). Kept separate so it can be unit-tested.

Test Plan (MEM_LATENCY=2):
- Single fetch: i_req=1, i_addr=0x0000_0104, memory returns 0xDEADBEEF.
  - mem_addr=0x104 for 2 cycles.
  - i_ready pulses 3 cycles after the sampling edge; i_rdata = DE,AD,BE,EF.
  - mem_write_en stays 0.
- Unaligned data write: d_req=1, d_we=1, d_addr=0x203, d_wdata=0x11223344.
  - mem_addr=0x200.
  - mem_write_en high exactly one cycle (the second ACCESS cycle) with mem_data_in = 11,22,33,44.
  - d_ready pulses; d_rdata stays at its prior value.
- Simultaneous requests right after reset: data is granted first. Fetch is granted in the IDLE following data's RESP. Grant order D, I, then D again while both stay high.
- Reset mid-ACCESS: assert rst during the first ACCESS cycle.
  - All outputs go to 0 immediately, with no ready pulse.
  - After release, a held request restarts from IDLE with full latency.
- Request dropped mid-access: drop d_req after the grant. Access completes; d_ready still pulses at T+3; next state IDLE with busy=0.
- MEM_LATENCY=1 build: fetch completes with i_ready at T+2; mem_write_en (write case) high in the single ACCESS cycle.
